// File: rtl/pc_seq_unit.sv
// Program-counter unit: next-address select, PC register, incrementer and a
// bounded return-address stack with sticky overflow/underflow flags.
module pc_seq_unit #(
  parameter int                 ADDR_W    = 10,
  parameter int                 RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0]  INTR_VEC  = ADDR_W'('h3FF),
  parameter logic [ADDR_W-1:0]  RESET_VEC = ADDR_W'('h000)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              PC_LD,
  input  logic              PC_INC,
  input  logic [1:0]        PC_MUX_SEL,
  input  logic [ADDR_W-1:0] FROM_IMMED,
  input  logic [ADDR_W-1:0] FROM_STACK,
  input  logic              CALL_PUSH,
  input  logic              ERR_CLR,
  output logic [ADDR_W-1:0] PC_COUNT,
  output logic [ADDR_W-1:0] RAS_TOP,
  output logic              RAS_EMPTY,
  output logic              RAS_FULL,
  output logic              RAS_OVF,
  output logic              RAS_UNF
);

  localparam int PTR_W = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = $clog2(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus1;
  logic [PTR_W-1:0]  cnt_q, cnt_d, top_ptr;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_en;
  logic              ovf_q, unf_q, set_ovf, set_unf;

  assign pc_plus1  = pc_q + ADDR_W'(1);
  assign top_ptr   = cnt_q - PTR_W'(1);
  assign RAS_EMPTY = (cnt_q == '0);
  assign RAS_FULL  = (cnt_q == PTR_W'(RAS_DEPTH));
  assign RAS_TOP   = RAS_EMPTY ? '0 : ras_mem[top_ptr[IDX_W-1:0]];
  assign PC_COUNT  = pc_q;
  assign RAS_OVF   = ovf_q;
  assign RAS_UNF   = unf_q;

  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = cnt_q[IDX_W-1:0];
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (PC_LD) begin
      case (PC_MUX_SEL)
        2'd0: pc_d = FROM_IMMED;
        2'd1: pc_d = FROM_STACK;
        2'd2: pc_d = INTR_VEC;
        default: begin
          // return; with CALL_PUSH the top entry is swapped in place
          if (RAS_EMPTY) begin
            set_unf = 1'b1;
          end else begin
            pc_d = RAS_TOP;
            if (CALL_PUSH) begin
              wr_en  = 1'b1;
              wr_idx = top_ptr[IDX_W-1:0];
            end else begin
              cnt_d = top_ptr;
            end
          end
        end
      endcase
      if (CALL_PUSH && PC_MUX_SEL != 2'd3) begin
        if (RAS_FULL) begin
          set_ovf = 1'b1;
        end else begin
          wr_en = 1'b1;
          cnt_d = cnt_q + PTR_W'(1);
        end
      end
    end else if (PC_INC) begin
      pc_d = pc_plus1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q  <= RESET_VEC;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ovf_q <= set_ovf | (ovf_q & ~ERR_CLR);
      unf_q <= set_unf | (unf_q & ~ERR_CLR);
    end
  end

  // storage is don't-care beyond the count, so it carries no reset
  always_ff @(posedge CLK) begin
    if (wr_en) ras_mem[wr_idx] <= pc_plus1;
  end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: directed scenarios plus randomized
// traffic against a queue-based model of the PC and return-address stack.
module tb_pc_seq_unit;
  localparam int AW    = 10;
  localparam int DEPTH = 8;
  localparam int MASK  = (1 << AW) - 1;
  localparam int INTR  = 'h3FF;
  localparam int RVEC  = 'h000;

  logic          CLK, RST_N, PC_LD, PC_INC, CALL_PUSH, ERR_CLR;
  logic [1:0]    PC_MUX_SEL;
  logic [AW-1:0] FROM_IMMED, FROM_STACK;
  logic [AW-1:0] PC_COUNT, RAS_TOP;
  logic          RAS_EMPTY, RAS_FULL, RAS_OVF, RAS_UNF;

  pc_seq_unit #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .INTR_VEC(10'h3FF), .RESET_VEC(10'h000)) dut (
    .CLK(CLK), .RST_N(RST_N), .PC_LD(PC_LD), .PC_INC(PC_INC), .PC_MUX_SEL(PC_MUX_SEL),
    .FROM_IMMED(FROM_IMMED), .FROM_STACK(FROM_STACK), .CALL_PUSH(CALL_PUSH), .ERR_CLR(ERR_CLR),
    .PC_COUNT(PC_COUNT), .RAS_TOP(RAS_TOP), .RAS_EMPTY(RAS_EMPTY), .RAS_FULL(RAS_FULL),
    .RAS_OVF(RAS_OVF), .RAS_UNF(RAS_UNF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int m_pc;
  int m_q[$];
  bit m_ovf, m_unf;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_top();
    return (m_q.size() != 0) ? m_q[$] : 0;
  endfunction

  task automatic model_reset();
    m_pc = RVEC;
    m_q.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  // Applies one clock edge worth of architectural behaviour.
  task automatic model_step();
    int ret;
    ret = (m_pc + 1) & MASK;
    if (ERR_CLR) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (PC_LD) begin
      if (PC_MUX_SEL == 2'd3) begin
        if (m_q.size() == 0) m_unf = 1;
        else begin
          int t;
          t = m_q.pop_back();
          if (CALL_PUSH) m_q.push_back(ret);
          m_pc = t;
        end
      end else begin
        m_pc = (PC_MUX_SEL == 2'd0) ? int'(FROM_IMMED) :
               (PC_MUX_SEL == 2'd1) ? int'(FROM_STACK) : INTR;
        if (CALL_PUSH) begin
          if (m_q.size() == DEPTH) m_ovf = 1;
          else m_q.push_back(ret);
        end
      end
    end else if (PC_INC) begin
      m_pc = ret;
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("pc_count", PC_COUNT, m_pc);
      chk("ras_top", RAS_TOP, m_top());
      chk("ras_empty", RAS_EMPTY, m_q.size() == 0);
      chk("ras_full", RAS_FULL, m_q.size() == DEPTH);
      chk("ras_ovf", RAS_OVF, m_ovf);
      chk("ras_unf", RAS_UNF, m_unf);
    end
  end

  task automatic idle();
    PC_LD = 0; PC_INC = 0; PC_MUX_SEL = 0; CALL_PUSH = 0; ERR_CLR = 0;
    FROM_IMMED = 0; FROM_STACK = 0;
  endtask

  task automatic step(input bit ld, input bit inc, input logic [1:0] sel,
                      input int imm, input int stk, input bit cp, input bit clr);
    PC_LD = ld; PC_INC = inc; PC_MUX_SEL = sel; CALL_PUSH = cp; ERR_CLR = clr;
    FROM_IMMED = AW'(imm); FROM_STACK = AW'(stk);
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle();
    RST_N = 0;
    #1;
    model_reset();
    chk("rst_pc", PC_COUNT, RVEC);
    chk("rst_empty", RAS_EMPTY, 1);
    @(negedge CLK);
    #1;
    RST_N = 1;
  endtask

  initial begin
    idle();
    RST_N = 0;
    model_reset();
    @(negedge CLK);
    #1;
    chk_en = 1;
    chk("reset_pc", PC_COUNT, 0);
    chk("reset_empty", RAS_EMPTY, 1);
    chk("reset_full", RAS_FULL, 0);
    chk("reset_flags", {RAS_OVF, RAS_UNF}, 0);
    RST_N = 1;

    // increment sequence and asynchronous reset mid-stream
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 0, 0, 0, 0, 0);
      chk("inc_seq", PC_COUNT, i);
    end
    PC_INC = 1;
    #2;
    RST_N = 0;
    #1;
    chk("async_rst", PC_COUNT, 0);
    model_reset();
    @(negedge CLK);
    #1;
    PC_INC = 0;
    RST_N = 1;

    // wrap, interrupt vector, load beats increment
    step(1, 0, 2, 0, 0, 0, 0);
    chk("intr_vec", PC_COUNT, 'h3FF);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("inc_wrap", PC_COUNT, 0);
    step(1, 0, 2, 0, 0, 0, 0);
    step(1, 1, 0, 'h055, 0, 0, 0);
    chk("ld_wins", PC_COUNT, 'h055);
    step(1, 0, 1, 0, 'h2AB, 0, 0);
    chk("from_stack", PC_COUNT, 'h2AB);

    // call then return
    step(1, 0, 0, 'h010, 0, 0, 0);
    step(1, 0, 0, 'h100, 0, 1, 0);
    chk("call_pc", PC_COUNT, 'h100);
    chk("call_top", RAS_TOP, 'h011);
    step(1, 0, 3, 0, 0, 0, 0);
    chk("ret_pc", PC_COUNT, 'h011);
    chk("ret_empty", RAS_EMPTY, 1);

    // fill past capacity, then unwind in LIFO order
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 0, 'h200 + i, 0, 1, 0);
      if (i == 7) begin
        chk("full_8", RAS_FULL, 1);
        chk("no_ovf_8", RAS_OVF, 0);
      end
    end
    chk("ovf_9", RAS_OVF, 1);
    chk("ovf_pc_loads", PC_COUNT, 'h208);
    for (int r = 0; r < 8; r++) begin
      step(1, 0, 3, 0, 0, 0, 0);
      chk("lifo_ret", PC_COUNT, (r < 7) ? ('h207 - r) : 'h012);
    end
    chk("unwound_empty", RAS_EMPTY, 1);
    chk("ovf_sticky", RAS_OVF, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("ovf_clr", RAS_OVF, 0);

    // underflow, clear, and new event beating clear
    step(1, 0, 0, 'h020, 0, 0, 0);
    step(1, 0, 3, 0, 0, 0, 0);
    chk("unf_pc_hold", PC_COUNT, 'h020);
    chk("unf_set", RAS_UNF, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("unf_clr", RAS_UNF, 0);
    step(1, 0, 3, 0, 0, 1, 1);
    chk("swap_empty_unf", RAS_UNF, 1);
    chk("swap_empty_pc", PC_COUNT, 'h020);
    chk("swap_empty_cnt", RAS_EMPTY, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // swap: return to old top, push return address in its place
    step(1, 0, 0, 'h03F, 0, 0, 0);
    step(1, 0, 0, 'h030, 0, 1, 0);
    chk("pre_swap_top", RAS_TOP, 'h040);
    step(1, 0, 3, 0, 0, 1, 0);
    chk("swap_pc", PC_COUNT, 'h040);
    chk("swap_top", RAS_TOP, 'h031);
    step(1, 0, 3, 0, 0, 0, 0);
    chk("swap_cnt_pop", PC_COUNT, 'h031);
    chk("swap_cnt_empty", RAS_EMPTY, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("push_no_ld", RAS_EMPTY, 1);

    // randomized traffic with shifting call/return bias
    for (int c = 0; c < 3000; c++) begin
      int pcall;
      bit ld, cp;
      logic [1:0] sel;
      if (c % 500 == 499) do_reset();
      pcall = ((c / 250) % 3 == 0) ? 70 : ((c / 250) % 3 == 1) ? 40 : 15;
      ld  = ($urandom_range(0, 99) < 50);
      cp  = ($urandom_range(0, 99) < pcall);
      sel = ($urandom_range(0, 99) < (100 - pcall)) ? 2'd3 : 2'($urandom_range(0, 2));
      step(ld, $urandom_range(0, 1) == 1, sel, $urandom_range(0, MASK),
           $urandom_range(0, MASK), cp, $urandom_range(0, 99) < 5);
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
